// File: rtl/wb_csr_pkg.sv
// Shared types and constants for the Wishbone-to-CSR bridge.
package wb_csr_pkg;

    // Bridge FSM states
    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RMW_WAIT,
        RMW_WR,
        ACK
    } state_e;

    localparam int READ_LAT_DEF = 1;   // default CSR read latency in edges
    localparam int MAX_LAT      = 4;   // largest latency the counter is sized for
    localparam int CNT_W        = 3;   // latency counter width

endpackage

// File: rtl/wb_csr_bytemerge.sv
// Byte-lane merge: each byte comes from new_i where sel_i is set, else from old_i.
module wb_csr_bytemerge
    import wb_csr_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] merged_o
);

    // One mux per byte lane
    for (genvar n = 0; n < 4; n++) begin : g_byte
        assign merged_o[8*n +: 8] = sel_i[n] ? new_i[8*n +: 8] : old_i[8*n +: 8];
    end

endmodule

// File: rtl/wb_csr_bridge.sv
// Wishbone classic slave to synchronous CSR bus bridge. Partial-byte writes
// are turned into read-modify-write so CSR slaves only see full-word writes.
module wb_csr_bridge
    import wb_csr_pkg::*;
#(
    parameter int CSR_AW   = 14,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [2:0]        wb_cti_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [31:0]       csr_do,
    input  logic [31:0]       csr_di
);

    if (READ_LAT < 1 || READ_LAT > MAX_LAT) begin : g_bad_lat
        $error("wb_csr_bridge: READ_LAT must be 1..4");
    end

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LAT);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic [31:0]         rdat_q, rdat_d;
    logic [CSR_AW-1:0]   csr_a_q, csr_a_d;
    logic                csr_we_q, csr_we_d;
    logic [31:0]         csr_do_q, csr_do_d;
    logic [31:0]         wdat_q, wdat_d;
    logic [3:0]          sel_q, sel_d;
    logic [31:0]         merged;

    // Only the word-address bits and the handshake matter; the rest is ignored
    logic unused_ok;
    assign unused_ok = ^{wb_cti_i, wb_adr_i[31:CSR_AW+2], wb_adr_i[1:0]};

    wb_csr_bytemerge u_merge (
        .old_i    (csr_di),
        .new_i    (wdat_q),
        .sel_i    (sel_q),
        .merged_o (merged)
    );

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            csr_a_q  <= '0;
            csr_we_q <= 1'b0;
            csr_do_q <= '0;
            wdat_q   <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            csr_a_q  <= csr_a_d;
            csr_we_q <= csr_we_d;
            csr_do_q <= csr_do_d;
            wdat_q   <= wdat_d;
            sel_q    <= sel_d;
        end
    end

    // Next-state logic. Full and null writes pass through RMW_WR as their
    // single commit cycle, which puts their ack at edge 1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        rdat_d   = rdat_q;
        csr_a_d  = csr_a_q;
        csr_we_d = 1'b0;
        csr_do_d = csr_do_q;
        wdat_d   = wdat_q;
        sel_d    = sel_q;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    csr_a_d = wb_adr_i[CSR_AW+1:2];
                    wdat_d  = wb_dat_i;
                    sel_d   = wb_sel_i;
                    if (!wb_we_i) begin
                        state_d = RD_WAIT;
                        cnt_d   = LAT_INIT;
                    end else if (wb_sel_i == 4'hF) begin
                        csr_do_d = wb_dat_i;
                        csr_we_d = 1'b1;
                        state_d  = RMW_WR;
                    end else if (wb_sel_i == 4'h0) begin
                        state_d = RMW_WR;
                    end else begin
                        state_d = RMW_WAIT;
                        cnt_d   = LAT_INIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    rdat_d  = csr_di;
                    ack_d   = wb_cyc_i;
                    state_d = wb_cyc_i ? ACK : IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RMW_WAIT: begin
                // Once the read is committed the write is always issued
                if (cnt_q == '0) begin
                    csr_do_d = merged;
                    csr_we_d = 1'b1;
                    state_d  = RMW_WR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RMW_WR: begin
                ack_d   = wb_cyc_i;
                state_d = wb_cyc_i ? ACK : IDLE;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wb_dat_o = rdat_q;
    assign wb_ack_o = ack_q;
    assign csr_a    = csr_a_q;
    assign csr_we   = csr_we_q;
    assign csr_do   = csr_do_q;

endmodule

// File: tb/tb_wb_csr_bridge.sv
// Randomised self-checking bench: one bridge with READ_LAT=1, one with 4,
// a latency-honest CSR memory model and a word-level reference memory.
module tb_wb_csr_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0, dat = '0;
    logic [2:0]  cti = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic        dsel = 1'b0;

    logic        cyc1, cyc4;
    logic [31:0] dat_o1, dat_o4, do1, do4, di1, di4;
    logic        ack1, ack4, we1, we4;
    logic [13:0] a1, a4;

    logic        ack, csr_we;
    logic [31:0] dat_o, csr_do;
    logic [13:0] csr_a;

    // CSR memory model
    logic [31:0] mem [16];
    logic [7:0]  age = '0;
    logic        fresh = 1'b0;
    logic        pre_en = 1'b0;
    logic [3:0]  pre_key = '0;
    logic [31:0] pre_dat = '0;

    // Reference state
    logic [31:0] exp_mem [16];
    logic [31:0] last_rd [2];
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign cyc1 = cyc & ~dsel;
    assign cyc4 = cyc & dsel;

    wb_csr_bridge #(.CSR_AW(14), .READ_LAT(1)) dut (
        .sys_clk(clk), .sys_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o1),
        .wb_cti_i(cti), .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc1), .wb_stb_i(stb),
        .wb_ack_o(ack1), .csr_a(a1), .csr_we(we1), .csr_do(do1), .csr_di(di1));

    wb_csr_bridge #(.CSR_AW(14), .READ_LAT(4)) dut4 (
        .sys_clk(clk), .sys_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o4),
        .wb_cti_i(cti), .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc4), .wb_stb_i(stb),
        .wb_ack_o(ack4), .csr_a(a4), .csr_we(we4), .csr_do(do4), .csr_di(di4));

    assign ack    = dsel ? ack4   : ack1;
    assign dat_o  = dsel ? dat_o4 : dat_o1;
    assign csr_we = dsel ? we4    : we1;
    assign csr_do = dsel ? do4    : do1;
    assign csr_a  = dsel ? a4     : a1;

    // Read data is garbage until the address has been held for the latency
    assign di1 = (age >= 8'd1) ? mem[a1[3:0]] : {24'hBAD000, age};
    assign di4 = (age >= 8'd4) ? mem[a4[3:0]] : {24'hBAD000, age};

    always @(posedge clk) begin
        if (pre_en) mem[pre_key] <= pre_dat;
        if (we1) mem[a1[3:0]] <= do1;
        if (we4) mem[a4[3:0]] <= do4;
        if (fresh) age <= '0;
        else if (age != 8'hFF) age <= age + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (nw & mask) | (old & ~mask);
    endfunction

    task automatic reset_chk();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_a", 32'(csr_a), 32'd0);
        chk("rst_we", 32'(csr_we), 32'd0);
        chk("rst_do", csr_do, 32'd0);
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pre_en  = 1'b1;
            pre_key = 4'(i);
            pre_dat = $urandom;
            exp_mem[i] = pre_dat;
        end
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // One complete bus transaction on the selected bridge, checked against
    // the reference: address, write pulse count/data, ack latency/width, data.
    task automatic txn(input logic we_v, input logic [31:0] adr_v, input logic [31:0] dat_v,
                       input logic [3:0] sel_v, input bit drop);
        int lat, exp_k, exp_p, pulses, ack_k;
        bit acked;
        logic [13:0] word;
        logic [3:0]  key;
        logic [31:0] exp_do;
        lat    = dsel ? 4 : 1;
        word   = adr_v[15:2];
        key    = word[3:0];
        exp_do = ref_merge(exp_mem[key], dat_v, sel_v);
        exp_p  = (we_v && sel_v != 4'h0) ? 1 : 0;
        if (!we_v) exp_k = lat + 1;
        else if (sel_v == 4'hF || sel_v == 4'h0) exp_k = 1;
        else exp_k = lat + 2;
        pulses = 0; ack_k = -1; acked = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = we_v; adr = adr_v; dat = dat_v; sel = sel_v;
        cti = 3'($urandom); fresh = 1'b1;
        for (int k = 0; k < exp_k + 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                fresh = 1'b0;
                chk("csr_a", 32'(csr_a), 32'(word));
                adr = $urandom; dat = $urandom; sel = 4'($urandom); we = 1'($urandom);
            end
            if (csr_we) begin
                pulses++;
                chk("csr_do", csr_do, exp_do);
            end
            if (acked) begin
                chk("ack_w", 32'(ack), 32'd0);
                break;
            end
            if (ack) begin
                acked = 1; ack_k = k; cyc = 1'b0; stb = 1'b0;
                if (!we_v) chk("rd_dat", dat_o, exp_mem[key]);
            end
            if (drop && k == 1) begin
                cyc = 1'b0; stb = 1'b0;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        if (drop) chk("no_ack", 32'(acked), 32'd0);
        else chk("ack_lat", 32'(ack_k), 32'(exp_k));
        chk("we_cnt", 32'(pulses), 32'(exp_p));
        if (we_v && sel_v != 4'h0) exp_mem[key] = exp_do;
        if (!we_v && !drop) last_rd[dsel] = exp_mem[key];
        else chk("dat_hold", dat_o, last_rd[dsel]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int abort_ack;
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dsel = 1'b0; #1; reset_chk();
        dsel = 1'b1; #1; reset_chk();
        dsel = 1'b0;
        preload();

        // Directed cases on READ_LAT=1
        txn(1'b1, 32'h0000000C, 32'hDEADBEEF, 4'hF, 0);
        txn(1'b0, 32'h0000000C, 32'h0, 4'h0, 0);
        chk("tp_rd", dat_o, 32'hDEADBEEF);
        txn(1'b1, 32'h00000010, 32'h12345678, 4'hF, 0);
        txn(1'b1, 32'h00000014, 32'hAABBCCDD, 4'hF, 0);
        txn(1'b1, 32'h00000014, 32'h11223344, 4'b0101, 0);
        chk("tp_rmw", mem[5], 32'hAA22CC44);

        // Null write followed by a request held across the ack
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'h0; adr = 32'h20; dat = $urandom;
        @(negedge clk);
        chk("b2b_we0", 32'(csr_we), 32'd0);
        chk("b2b_ack0", 32'(ack), 32'd0);
        @(negedge clk);
        chk("b2b_ack1", 32'(ack), 32'd1);
        chk("b2b_we1", 32'(csr_we), 32'd0);
        adr = 32'h24; dat = 32'hCAFEF00D; sel = 4'hF;
        @(negedge clk);
        chk("b2b_ack2", 32'(ack), 32'd0);
        chk("b2b_noacc", 32'(csr_we), 32'd0);
        @(negedge clk);
        chk("b2b_we3", 32'(csr_we), 32'd1);
        chk("b2b_a3", 32'(csr_a), 32'd9);
        chk("b2b_do", csr_do, 32'hCAFEF00D);
        @(negedge clk);
        chk("b2b_ack4", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0;
        exp_mem[9] = 32'hCAFEF00D;
        @(negedge clk);
        chk("b2b_ackw", 32'(ack), 32'd0);
        chk("b2b_dat", dat_o, last_rd[0]);

        // Cycle dropped during a read-modify-write: write still lands, no ack
        txn(1'b1, 32'h0000001C, 32'h55667788, 4'b1010, 1);

        // READ_LAT=4 bridge
        dsel = 1'b1;
        txn(1'b1, 32'h00000018, 32'h0BADCAFE, 4'hF, 0);
        txn(1'b0, 32'h00000018, 32'h0, 4'h0, 0);
        chk("tp_rd4", dat_o, 32'h0BADCAFE);
        txn(1'b1, 32'h00000018, 32'h99887766, 4'b0011, 0);

        // Randomised traffic across both bridges
        for (int i = 0; i < 80; i++) begin
            logic [3:0] s;
            case ($urandom_range(0, 3))
                0: s = 4'hF;
                1: s = 4'h0;
                default: s = 4'($urandom);
            endcase
            dsel = 1'($urandom);
            txn(1'($urandom), $urandom, $urandom, s, 0);
        end

        // Reset in the middle of a READ_LAT=4 read
        dsel = 1'b1;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h28; fresh = 1'b1;
        @(negedge clk);
        fresh = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_chk();
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        abort_ack = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack) abort_ack++;
        end
        chk("abort_noack", 32'(abort_ack), 32'd0);
        last_rd[0] = '0; last_rd[1] = '0;
        txn(1'b0, 32'h00000028, 32'h0, 4'h0, 0);
        dsel = 1'b0;
        txn(1'b0, 32'h00000014, 32'h0, 4'h0, 0);

        for (int i = 0; i < 16; i++) chk("mem", mem[i], exp_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_csr_bridge.md
Name: wb_csr_bridge

Overview:
- Wishbone slave that sits on one slave port of the system interconnect and turns bus cycles into accesses on a simple synchronous CSR bus for peripheral registers (PWM, sensor I/F, timers).
- Handles configurable CSR read latency.
- Performs a read-modify-write for partial-byte writes so CSR slaves only ever see full 32-bit writes.
- One transaction in flight; every access is a classic single-beat cycle.

Parameters:
- CSR_AW, 14, CSR word-address width; csr_a = wb_adr_i[CSR_AW+1:2].
- READ_LAT, 1, edges from csr_a driven to csr_di valid (1..4).

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- wb_adr_i  in  32  byte address; bits above CSR_AW+1 and bits [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_cti_i  in  3  accepted and ignored.
- wb_sel_i  in  4  byte enables; bit n covers bits [8n+7:8n].
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  one-cycle acknowledge.
- csr_a  out  CSR_AW  CSR word address, registered.
- csr_we  out  1  CSR write strobe, one-cycle pulse.
- csr_do  out  32  CSR write data.
- csr_di  in  32  CSR read data, valid READ_LAT edges after csr_a.

Behaviour:
- Reset (sync, sys_rst=1 at an edge):
  - State returns to IDLE.
  - wb_ack_o=0, wb_dat_o=0, csr_a=0, csr_we=0, csr_do=0, latency counter=0.
  - A reset mid-transaction aborts it. csr_we drops at the reset edge and no ack is issued.
- States: IDLE, RD_WAIT, RMW_WAIT, RMW_WR, ACK.
- Accept condition: IDLE & wb_cyc_i & wb_stb_i. The accept edge is edge 0. At edge 0, csr_a <= wb_adr_i[CSR_AW+1:2].
- Read (we=0):
  - Edge 0: go to RD_WAIT, counter <= READ_LAT.
  - Each edge in RD_WAIT decrements the counter.
  - Edge READ_LAT+1: wb_dat_o <= csr_di, wb_ack_o <= 1, go to ACK.
  - With READ_LAT=1, ack is high after edge 2.
- Full write (we=1, sel=4'hF):
  - Edge 0: csr_do <= wb_dat_i, csr_we <= 1, go to ACK with wb_ack_o <= 1 at edge 1.
  - csr_we is high for exactly the cycle after edge 0.
- Partial write (we=1, sel not 4'hF and not 0):
  - Edge 0: csr_we=0, go to RMW_WAIT, counter <= READ_LAT.
  - Edge READ_LAT+1: csr_do <= merge(csr_di, wb_dat_i, wb_sel_i), csr_we <= 1, go to RMW_WR.
  - Edge READ_LAT+2: csr_we <= 0, wb_ack_o <= 1, go to ACK.
  - Merge rule: byte n = sel[n] ? wb_dat_i byte : csr_di byte.
  - wb_dat_o is not updated by writes.
- Null write (we=1, sel=0): no CSR activity; ack at edge 1.
- ACK state:
  - wb_ack_o is high for exactly one cycle; the edge leaving ACK clears it and goes to IDLE.
  - stb is ignored in ACK, so back-to-back requests have one dead cycle. The earliest next accept is the edge after ack falls.
- cyc drop mid-transaction:
  - The FSM runs to completion. A committed RMW write phase is still issued (atomic).
  - wb_ack_o is only set if wb_cyc_i=1 in the cycle it would be registered; otherwise return to IDLE silently.
- Request fields are sampled only at edge 0. wb_dat_i and wb_sel_i are latched internally for RMW, so master changes after accept have no effect.
- csr_a holds its value between transactions; csr_do holds its last written value.
- Counter width is 3 bits. READ_LAT outside 1..4 is a static configuration error.

Decomposition:
- Shared package wb_csr_pkg holds:
  - the state encoding constants (IDLE, RD_WAIT, RMW_WAIT, RMW_WR, ACK);
  - the READ_LAT default;
  - the maximum latency constant, 4.
- One combinational sub-module, wb_csr_bytemerge: inputs old[31:0], new[31:0], sel[3:0]; output merged[31:0]. It is unit-testable alone.
- The FSM, counter and registers stay in wb_csr_bridge.

Test Plan:
- Read, READ_LAT=1: CSR model returns 32'hDEADBEEF at word 3; master reads 32'h0000000C. Required: csr_a=3 after edge 0, ack only after edge 2, wb_dat_o=32'hDEADBEEF, ack width 1 cycle.
- Full write: write 32'h12345678, sel=4'hF, to byte address 32'h10. Required: csr_a=4, csr_we high for exactly 1 cycle with csr_do=32'h12345678, ack after edge 1.
- RMW: CSR word 5 holds 32'hAABBCCDD; write 32'h11223344 with sel=4'b0101 at address 32'h14. Required: csr_we pulses once with csr_do=32'hAA22CC44, ack after edge 3 (READ_LAT=1).
- Null write and back-to-back: write with sel=0 gives ack after edge 1 and csr_we never asserted. A second request held on stb is accepted on the edge after ack falls, not during ack.
- READ_LAT=4: read returns csr_di sampled 4 edges after csr_a; ack after edge 5. A csr_di value change at edge 3 must not be captured.
- Abort cases:
  - RMW with cyc dropped after edge 1: csr_we still pulses, wb_ack_o stays 0, FSM returns to IDLE.
  - sys_rst asserted in RD_WAIT: all outputs 0 at the next edge, no ack, next read completes normally.
